// File: rtl/sc_store_narrow_pkg.sv
// Shared encodings for the narrowing store unit: access sizes, FSM states, lane helper.
package sc_store_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Big-endian mirrors the byte lane; the half lane is then bit 1 of the byte lane.
  function automatic logic [1:0] byte_lane(input logic [1:0] addr_lo, input bit little_end);
    return little_end ? addr_lo : (2'd3 - addr_lo);
  endfunction

endpackage

// File: rtl/sc_store_narrow_if.sv
// Word-wide data memory port driven by the store unit (master) and served by the memory (slave).
interface sc_store_narrow_if #(
  parameter int ADDR_W = 32
) ();
  // Request is valid/ready style: o_mem_re is held with a stable o_mem_addr until i_mem_rvalid,
  // and o_mem_we is held with stable o_mem_addr/o_mem_wdata until i_mem_wready; each transfer
  // completes on the rising edge where request and response are both high.
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_re;
  logic [31:0]       i_mem_rdata;
  logic              i_mem_rvalid;
  logic              o_mem_we;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_wready;

  modport master (
    output o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
    input  i_mem_rdata, i_mem_rvalid, i_mem_wready
  );

  modport slave (
    input  o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
    output i_mem_rdata, i_mem_rvalid, i_mem_wready
  );
endinterface

// File: rtl/sc_store_narrow_lane_merge.sv
// Combinational read-modify-write merge: drops the narrowed value into its lane of the old word.
module sc_lane_merge
  import sc_store_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SIZE_BYTE: merged_o[{lane_i, 3'b000} +: 8] = data_i[7:0];
      SIZE_HALF: begin
        if (lane_i[1]) merged_o[31:16] = data_i[15:0];
        else           merged_o[15:0]  = data_i[15:0];
      end
      default:   merged_o = data_i;
    endcase
  end

endmodule

// File: rtl/sc_store_narrow.sv
// Narrowing store unit: latches a store request, checks alignment/overflow, then performs a
// read-modify-write (byte/half) or a plain write (word) on a word-only memory port.
module sc_store_narrow
  import sc_store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit LITTLE_END = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  input  logic [1:0]        i_size,
  input  logic              i_extSel,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic              o_misalign,
  output state_t            o_state,
  sc_store_narrow_if.master mem
);

  state_t            state_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic              ext_q;
  logic              busy_q, done_q, ovf_q, mis_q, re_q, we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       wdata_q;

  logic              misalign_d;
  logic              ovf_d;
  logic [31:0]       merged_d;
  logic [1:0]        lane_d;

  assign lane_d = byte_lane(addr_lo_q, LITTLE_END);

  always_comb begin
    misalign_d = 1'b0;
    if (size_q == SIZE_HALF) misalign_d = addr_lo_q[0];
    else if (size_q[1])      misalign_d = (addr_lo_q != 2'b00);
  end

  // Signed narrowing is lossless only when all bits above the kept sign bit copy it.
  always_comb begin
    ovf_d = 1'b0;
    case (size_q)
      SIZE_BYTE: ovf_d = ext_q ? !((&data_q[31:7]) || !(|data_q[31:7])) : (|data_q[31:8]);
      SIZE_HALF: ovf_d = ext_q ? !((&data_q[31:15]) || !(|data_q[31:15])) : (|data_q[31:16]);
      default:   ovf_d = 1'b0;
    endcase
  end

  sc_lane_merge u_merge (
    .old_word_i (mem.i_mem_rdata),
    .data_i     (data_q),
    .lane_i     (lane_d),
    .size_i     (size_q),
    .merged_o   (merged_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_lo_q  <= '0;
      data_q     <= '0;
      size_q     <= '0;
      ext_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      mis_q      <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_lo_q  <= i_addr[1:0];
            data_q     <= i_data;
            size_q     <= i_size;
            ext_q      <= i_extSel;
            mem_addr_q <= {i_addr[ADDR_W-1:2], 2'b00};
            busy_q     <= 1'b1;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (misalign_d) begin
            mis_q   <= 1'b1;
            ovf_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (size_q[1]) begin
            wdata_q <= data_q;
            we_q    <= 1'b1;
            ovf_q   <= 1'b0;
            state_q <= WR;
          end else begin
            ovf_q   <= ovf_d;
            re_q    <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          if (mem.i_mem_rvalid) begin
            re_q    <= 1'b0;
            wdata_q <= merged_d;
            we_q    <= 1'b1;
            state_q <= WR;
          end
        end
        WR: begin
          if (mem.i_mem_wready) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ovf_q   <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_ovf           = ovf_q;
  assign o_misalign      = mis_q;
  assign o_state         = state_q;
  assign mem.o_mem_addr  = mem_addr_q;
  assign mem.o_mem_re    = re_q;
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_wdata = wdata_q;

endmodule
